// File: rtl/shift_reg_arbiter.sv
// Round-robin arbiter that shares one external SIPO shift register between two requesters.
// Each granted word is shifted in MSB-first, then read back and compared with the word sent.
module shift_reg_arbiter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             sr_d_in,
   output logic             sr_en,
   input  logic [WIDTH-1:0] sr_q,
   output logic             done,
   output logic             done_id,
   output logic [WIDTH-1:0] result,
   output logic             match
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StShift, StCapture, StDone} state_e;

   state_e            state_q;
   logic [WIDTH-1:0]  hold_q;
   logic [WIDTH-1:0]  result_q;
   logic [CntW-1:0]   cnt_q;
   logic              grant_q;
   logic              last_q;
   logic              match_q;
   logic              done_q;
   logic              done_id_q;

   logic              sel;
   logic              accept;
   logic [CntW-1:0]   bit_idx;

   // On a tie the requester that was not served last wins.
   always_comb begin
      sel        = (req0_valid && req1_valid) ? ~last_q : req1_valid;
      req0_ready = (state_q == StIdle) && !sel && req0_valid;
      req1_ready = (state_q == StIdle) && sel && req1_valid;
      accept     = req0_ready | req1_ready;
      bit_idx    = CntW'(WIDTH - 1) - cnt_q;
      sr_en      = (state_q == StShift);
      sr_d_in    = sr_en & hold_q[bit_idx];
   end

   assign done    = done_q;
   assign done_id = done_id_q;
   assign result  = result_q;
   assign match   = match_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         hold_q    <= '0;
         result_q  <= '0;
         cnt_q     <= '0;
         grant_q   <= 1'b0;
         last_q    <= 1'b1;
         match_q   <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  hold_q  <= sel ? req1_data : req0_data;
                  grant_q <= sel;
                  cnt_q   <= '0;
                  state_q <= StShift;
               end
            end
            StShift: begin
               if (cnt_q == CntW'(WIDTH - 1)) begin
                  cnt_q   <= '0;
                  state_q <= StCapture;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StCapture: begin
               result_q  <= sr_q;
               match_q   <= (sr_q == hold_q);
               done_q    <= 1'b1;
               done_id_q <= grant_q;
               state_q   <= StDone;
            end
            StDone: begin
               done_q  <= 1'b0;
               last_q  <= grant_q;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_reg_arbiter.sv
// Self-checking bench for shift_reg_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model with an external shift register model.
module tb_shift_reg_arbiter;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0_valid, req1_valid;
   logic [W-1:0] req0_data, req1_data;
   logic         req0_ready, req1_ready;
   logic         sr_d_in, sr_en;
   logic [W-1:0] sr_q;
   logic         done, done_id, match;
   logic [W-1:0] result;

   logic [W-1:0] sr_model = '0;
   logic [W-1:0] stuck_mask = '0;

   int checks = 0;
   int errors = 0;

   shift_reg_arbiter #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req0_valid(req0_valid),
      .req0_data (req0_data),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid),
      .req1_data (req1_data),
      .req1_ready(req1_ready),
      .sr_d_in   (sr_d_in),
      .sr_en     (sr_en),
      .sr_q      (sr_q),
      .done      (done),
      .done_id   (done_id),
      .result    (result),
      .match     (match)
   );

   always #5 clk = ~clk;

   // External shared register: serial in at bit 0, shifting toward the MSB; mask models stuck-at-0.
   always @(posedge clk) if (sr_en) sr_model <= {sr_model[W-2:0], sr_d_in};
   assign sr_q = sr_model & ~stuck_mask;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
      tick(); tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (done_id !== 1'b0) begin errors++; $display("FAIL reset_done_id got %b exp 0", done_id); end
      checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
      checks++; if (match !== 1'b0) begin errors++; $display("FAIL reset_match got %b exp 0", match); end
      checks++; if (sr_en !== 1'b0) begin errors++; $display("FAIL reset_sr_en got %b exp 0", sr_en); end
      checks++; if (sr_d_in !== 1'b0) begin errors++; $display("FAIL reset_sr_d_in got %b exp 0", sr_d_in); end
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single();
      logic [W-1:0] w;
      w = 4'b1011;
      req0_data = w; req0_valid = 1'b1;
      #1;
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         errors++; $display("FAIL single_ready got %b%b exp 10", req0_ready, req1_ready);
      end
      tick();
      req0_valid = 1'b0;
      for (int k = 0; k < W; k++) begin
         checks++; if (sr_en !== 1'b1 || sr_d_in !== w[W-1-k]) begin
            errors++; $display("FAIL single_shift%0d got en=%b d=%b exp en=1 d=%b", k, sr_en, sr_d_in, w[W-1-k]);
         end
         tick();
      end
      checks++; if (sr_en !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL single_capture got en=%b done=%b exp 0 0", sr_en, done);
      end
      tick();
      checks++; if (done !== 1'b1 || done_id !== 1'b0) begin
         errors++; $display("FAIL single_done got done=%b id=%b exp 1 0", done, done_id);
      end
      checks++; if (result !== w || match !== 1'b1) begin
         errors++; $display("FAIL single_result got %b m=%b exp %b m=1", result, match, w);
      end
      tick();
      checks++; if (done !== 1'b0 || result !== w) begin
         errors++; $display("FAIL single_hold got done=%b res=%b exp 0 %b", done, result, w);
      end
   endtask

   task automatic test_back_to_back();
      int acc_cyc[$];
      int acc_id[$];
      int d_id[$];
      logic [W-1:0] d_res[$];
      logic a0, a1;
      reset = 1'b1; tick(); reset = 1'b0;
      req0_data = 4'h5; req1_data = 4'hA; req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      for (int cyc = 0; cyc < 60 && d_id.size() < 2; cyc++) begin
         a0 = req0_ready; a1 = req1_ready;
         checks++; if (a0 && a1) begin errors++; $display("FAIL b2b_both_ready got 11 exp not both"); end
         if (a0) begin acc_cyc.push_back(cyc); acc_id.push_back(0); end
         if (a1) begin acc_cyc.push_back(cyc); acc_id.push_back(1); end
         tick();
         if (a0) req0_valid = 1'b0;
         if (a1) req1_valid = 1'b0;
         if (done) begin d_id.push_back(int'(done_id)); d_res.push_back(result); end
         #1;
      end
      checks++; if (d_id.size() != 2 || acc_id.size() != 2) begin
         errors++; $display("FAIL b2b_count got acc=%0d done=%0d exp 2 2", acc_id.size(), d_id.size());
      end else begin
         checks++; if (acc_id[0] != 0 || acc_id[1] != 1) begin
            errors++; $display("FAIL b2b_grant got %0d,%0d exp 0,1", acc_id[0], acc_id[1]);
         end
         checks++; if (acc_cyc[1] - acc_cyc[0] != W + 3) begin
            errors++; $display("FAIL b2b_spacing got %0d exp %0d", acc_cyc[1] - acc_cyc[0], W + 3);
         end
         checks++; if (d_id[0] != 0 || d_id[1] != 1) begin
            errors++; $display("FAIL b2b_done_id got %0d,%0d exp 0,1", d_id[0], d_id[1]);
         end
         checks++; if (d_res[0] !== 4'h5 || d_res[1] !== 4'hA) begin
            errors++; $display("FAIL b2b_result got %h,%h exp 5,a", d_res[0], d_res[1]);
         end
      end
   endtask

   task automatic test_fairness();
      logic [W-1:0] sent[$];
      logic [W-1:0] exp_w;
      logic a0, a1;
      int ndone;
      ndone = 0;
      req0_data = W'($urandom); req1_data = W'($urandom);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      for (int cyc = 0; cyc < 200 && ndone < 4; cyc++) begin
         a0 = req0_ready; a1 = req1_ready;
         checks++; if (a0 && a1) begin errors++; $display("FAIL fair_both_ready got 11 exp not both"); end
         if (a0) sent.push_back(req0_data);
         if (a1) sent.push_back(req1_data);
         tick();
         if (a0) req0_data = W'($urandom);
         if (a1) req1_data = W'($urandom);
         if (done) begin
            exp_w = (sent.size() > 0) ? sent.pop_front() : 'x;
            checks++; if (done_id !== ndone[0]) begin
               errors++; $display("FAIL fair_id%0d got %b exp %b", ndone, done_id, ndone[0]);
            end
            checks++; if (result !== exp_w || match !== 1'b1) begin
               errors++; $display("FAIL fair_res%0d got %h m=%b exp %h m=1", ndone, result, match, exp_w);
            end
            ndone++;
         end
         #1;
      end
      checks++; if (ndone != 4) begin errors++; $display("FAIL fair_count got %0d exp 4", ndone); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
   endtask

   task automatic test_stuck();
      bit seen;
      seen = 1'b0;
      stuck_mask = 4'b0100;
      req0_data = 4'hF; req0_valid = 1'b1;
      #1;
      for (int cyc = 0; cyc < 30 && !seen; cyc++) begin
         if (req0_ready) begin tick(); req0_valid = 1'b0; end else tick();
         if (done) begin
            seen = 1'b1;
            checks++; if (result !== 4'hB || match !== 1'b0) begin
               errors++; $display("FAIL stuck_result got %h m=%b exp b m=0", result, match);
            end
         end
      end
      checks++; if (!seen) begin errors++; $display("FAIL stuck_timeout got no done exp done"); end
      stuck_mask = '0;
      tick();
   endtask

   task automatic test_reset_mid();
      req0_valid = 1'b0; req1_data = 4'h6; req1_valid = 1'b1;
      #1;
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", req1_ready); end
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checks++; if (sr_en !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL rmid_abort got en=%b done=%b exp 0 0", sr_en, done);
      end
      checks++; if (result !== '0 || match !== 1'b0) begin
         errors++; $display("FAIL rmid_clear got %h m=%b exp 0 m=0", result, match);
      end
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL rmid_reaccept got %b exp 1", req1_ready); end
      tick();
      req1_valid = 1'b0;
      for (int k = 1; k < W + 2; k++) begin
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_early_done%0d got 1 exp 0", k); end
         tick();
      end
      checks++; if (done !== 1'b1 || done_id !== 1'b1 || result !== 4'h6 || match !== 1'b1) begin
         errors++; $display("FAIL rmid_done got d=%b id=%b r=%h m=%b exp 1 1 6 1", done, done_id, result, match);
      end
      tick();
   endtask

   task automatic test_pulse();
      int ndone, nready1;
      ndone = 0; nready1 = 0;
      req0_data = 4'h3; req0_valid = 1'b1;
      #1;
      tick();
      req0_valid = 1'b0;
      tick();
      req1_data = 4'h9; req1_valid = 1'b1;
      #1;
      if (req1_ready) nready1++;
      tick();
      req1_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (done) ndone++;
         if (req1_ready) nready1++;
         tick();
      end
      checks++; if (ndone != 1) begin errors++; $display("FAIL pulse_dones got %0d exp 1", ndone); end
      checks++; if (nready1 != 0) begin errors++; $display("FAIL pulse_ready1 got %0d exp 0", nready1); end
   endtask

   // Transaction-level model: age counts clocks since the accepting edge (0 = idle).
   task automatic test_random();
      int m_age;
      logic m_last, m_grant;
      logic [W-1:0] m_word, exp_res;
      logic e_r0, e_r1, e_en, e_d, e_done;
      reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; stuck_mask = '0;
      tick();
      reset = 1'b0;
      m_age = 0; m_last = 1'b1; m_grant = 1'b0; m_word = '0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         if (!req0_valid && $urandom_range(2) == 0) begin req0_valid = 1'b1; req0_data = W'($urandom); end
         else if (req0_valid && m_age != 0 && $urandom_range(7) == 0) req0_valid = 1'b0;
         if (!req1_valid && $urandom_range(2) == 0) begin req1_valid = 1'b1; req1_data = W'($urandom); end
         else if (req1_valid && m_age != 0 && $urandom_range(7) == 0) req1_valid = 1'b0;
         if (m_age == 0 && $urandom_range(9) == 0)
            stuck_mask = ($urandom_range(2) == 0) ? W'($urandom) : '0;
         #1;
         e_r0   = (m_age == 0) && req0_valid && (!req1_valid || m_last);
         e_r1   = (m_age == 0) && req1_valid && (!req0_valid || !m_last);
         e_en   = (m_age >= 1) && (m_age <= W);
         e_d    = e_en ? m_word[W - m_age] : 1'b0;
         e_done = (m_age == W + 2);
         exp_res = m_word & ~stuck_mask;
         checks++; if (req0_ready !== e_r0 || req1_ready !== e_r1) begin
            errors++; $display("FAIL rnd_ready c%0d got %b%b exp %b%b", cyc, req0_ready, req1_ready, e_r0, e_r1);
         end
         checks++; if (sr_en !== e_en || sr_d_in !== e_d) begin
            errors++; $display("FAIL rnd_sr c%0d got en=%b d=%b exp en=%b d=%b", cyc, sr_en, sr_d_in, e_en, e_d);
         end
         checks++; if (done !== e_done) begin
            errors++; $display("FAIL rnd_done c%0d got %b exp %b", cyc, done, e_done);
         end
         if (e_done) begin
            checks++; if (done_id !== m_grant || result !== exp_res || match !== (exp_res == m_word)) begin
               errors++; $display("FAIL rnd_txn c%0d got id=%b r=%h m=%b exp id=%b r=%h m=%b", cyc, done_id,
                                  result, match, m_grant, exp_res, (exp_res == m_word));
            end
         end
         @(posedge clk);
         if (m_age == 0) begin
            if (e_r0) begin m_grant = 1'b0; m_word = req0_data; m_age = 1; end
            else if (e_r1) begin m_grant = 1'b1; m_word = req1_data; m_age = 1; end
         end else if (m_age == W + 2) begin
            m_last = m_grant; m_age = 0;
         end else begin
            m_age++;
         end
         #1;
         if (e_r0) req0_valid = 1'b0;
         if (e_r1) req1_valid = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_fairness();
      test_stuck();
      test_reset_mid();
      test_pulse();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_reg_arbiter.md
Name: shift_reg_arbiter

Overview:
Controller that shares one external serial-in/parallel-out shift register (WIDTH bits, d_in enters bit 0, shifts toward MSB on enabled clocks) between two requesters. Each requester hands over a parallel word via valid/ready. The block grants round-robin, serialises the word MSB-first into the shared register, reads back the parallel contents, and reports completion with the requester ID. A compare flag indicates whether the readback matched the word sent.

Parameters:
WIDTH, 4, word width of the shared shift register and of each request word (2..16).

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
req0_valid  input  1  requester 0 has a word to send.
req0_data  input  WIDTH  requester 0 word; held stable while req0_valid=1.
req0_ready  output  1  requester 0 word accepted on this edge if req0_valid=1.
req1_valid  input  1  requester 1 has a word to send.
req1_data  input  WIDTH  requester 1 word.
req1_ready  output  1  requester 1 word accepted on this edge if req1_valid=1.
sr_d_in  output  1  serial bit to shared register.
sr_en  output  1  shift enable to shared register.
sr_q  input  WIDTH  parallel contents of shared register.
done  output  1  one-cycle pulse: transaction complete.
done_id  output  1  requester ID of completed transaction; valid when done=1.
result  output  WIDTH  captured sr_q of last transaction; holds until next capture.
match  output  1  result == word sent; updated with result.

Behaviour:
- States: IDLE, SHIFT, CAPTURE, DONE. Registered state, hold register (WIDTH), bit counter, grant_id, last_id.
- Reset (synchronous, priority over everything): state=IDLE, counter=0, last_id=1 (req0 wins first tie), result=0, match=0, done=0, done_id=0, hold=0. sr_en=0 and sr_d_in=0 in the cycle after reset.
- IDLE: sel = only valid requester; if both valid, sel = requester != last_id. reqN_ready = (state==IDLE) && (sel==N) && reqN_valid. This is combinational from valid/state/last_id. On an accepting edge: hold<=reqsel_data, grant_id<=sel, counter<=0, go to SHIFT. With no valid, stay in IDLE. Both ready never high together.
- SHIFT: sr_en=1, sr_d_in=hold[WIDTH-1-counter]. Counter increments each cycle. After exactly WIDTH SHIFT cycles (counter==WIDTH-1 on the edge), go to CAPTURE.
- CAPTURE: sr_en=0. On the edge: result<=sr_q, match<=(sr_q==hold). Go to DONE.
- DONE: done=1, done_id=grant_id. On the edge: last_id<=grant_id, go to IDLE.
- sr_en=0 and sr_d_in=0 in IDLE, CAPTURE and DONE. Ready=0 outside IDLE.
- Latency: accept edge T. SHIFT in cycles T+1..T+WIDTH. CAPTURE in cycle T+WIDTH+1. done high in cycle T+WIDTH+2. Next accept is possible at the end of cycle T+WIDTH+3. Throughput is one word per WIDTH+3 cycles.
- Requests arriving during a transaction are not lost. They wait (valid held) and are arbitrated in the next IDLE.
- Valid dropped before ready: no transfer, no side effect.
- Reset mid-transaction: transaction aborted, no done pulse, word discarded. result and match return to 0. The requester must resubmit.
- Round-robin is fair: with both valid continuously, grants alternate 0,1,0,1...

Test Plan:
- Single req0, WIDTH=4, data=4'b1011; external shift register model -> req0_ready 1 cycle; sr_en high 4 cycles with sr_d_in 1,0,1,1; done 6 cycles after accept edge; done_id=0, result=4'b1011, match=1.
- req0 and req1 both valid from reset (data 4'h5, 4'hA), held until accepted -> grants 0 then 1; results 4'h5 then 4'hA; done_id 0 then 1; accepts 7 cycles apart.
- Both valid continuously for 4 transactions -> done_id sequence 0,1,0,1; never two readys in one cycle.
- Shift register model with bit 2 stuck at 0, send 4'hF -> result=4'hB, match=0.
- reset asserted for 1 cycle during 2nd SHIFT cycle of req1 word -> no done; sr_en=0 next cycle; result=0; req1 re-accepted after reset releases while still valid.
- req1 pulses valid for 1 cycle while busy, then drops -> that word never accepted, no extra done.
